// File: rtl/ct_param_counter.sv
// rtl/ct_param_counter.sv - loadable up/down counter with wrap/saturate, terminal-count pulse and sticky overflow
module ct_param_counter #(
    parameter int DATA_WIDTH = 8,
    parameter bit SATURATE   = 1'b0,
    parameter bit ONE_SHOT   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr_ovf,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  tc,
    output logic                  ovf,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MAX = '1;

    state_t                st;
    logic [DATA_WIDTH-1:0] terminal;
    logic [DATA_WIDTH-1:0] stepped;
    logic                  boundary;
    logic                  step_hit;
    logic                  stepping;
    logic                  ovf_set;

    always_comb begin
        terminal = up ? MAX : '0;
        boundary = (count == terminal);
        stepped  = up ? (count + 1'b1) : (count - 1'b1);
        // A boundary step never re-announces the terminal value, even when saturating onto it.
        step_hit = !boundary && (stepped == terminal);
        stepping = !ld && en && (st == ST_RUN);
        ovf_set  = stepping && boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            st    <= ST_IDLE;
        end else begin
            if (ld) begin
                count <= data;
                st    <= ST_RUN;
                tc    <= 1'b0;
            end else if (stepping) begin
                if (!(SATURATE && boundary)) begin
                    count <= stepped;
                end
                tc <= step_hit;
                if (ONE_SHOT && step_hit) begin
                    st <= ST_DONE;
                end
            end else begin
                tc <= 1'b0;
            end

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_ct_param_counter.sv
// tb/tb_ct_param_counter.sv - randomized and directed bench for ct_param_counter (wrap, saturate, one-shot)
module tb_ct_param_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld = 1'b0;
    logic [7:0] data = 8'h00;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       clr_ovf = 1'b0;

    logic [7:0] d_count [3];
    logic       d_tc    [3];
    logic       d_ovf   [3];
    logic [1:0] d_state [3];

    int checks = 0;
    int failures = 0;

    // instance 0: wrap, 1: saturate, 2: one-shot
    bit cfg_sat [3] = '{1'b0, 1'b1, 1'b0};
    bit cfg_one [3] = '{1'b0, 1'b0, 1'b1};
    int m_count [3];
    int m_state [3];
    bit m_tc    [3];
    bit m_ovf   [3];

    always #5 clk = ~clk;

    ct_param_counter #(.DATA_WIDTH(8), .SATURATE(1'b0), .ONE_SHOT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .ld(ld), .data(data), .en(en), .up(up), .clr_ovf(clr_ovf),
        .count(d_count[0]), .tc(d_tc[0]), .ovf(d_ovf[0]), .state(d_state[0]));
    ct_param_counter #(.DATA_WIDTH(8), .SATURATE(1'b1), .ONE_SHOT(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .ld(ld), .data(data), .en(en), .up(up), .clr_ovf(clr_ovf),
        .count(d_count[1]), .tc(d_tc[1]), .ovf(d_ovf[1]), .state(d_state[1]));
    ct_param_counter #(.DATA_WIDTH(8), .SATURATE(1'b0), .ONE_SHOT(1'b1)) u_one (
        .clk(clk), .rst_n(rst_n), .ld(ld), .data(data), .en(en), .up(up), .clr_ovf(clr_ovf),
        .count(d_count[2]), .tc(d_tc[2]), .ovf(d_ovf[2]), .state(d_state[2]));

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_count[k] = 0;
            m_state[k] = 0;
            m_tc[k]    = 1'b0;
            m_ovf[k]   = 1'b0;
        end
    endfunction

    // Counter rules applied to the inputs presented before the coming edge.
    function automatic void model_step();
        int term;
        int nxt;
        bit hit;
        bit set;
        for (int k = 0; k < 3; k++) begin
            set = 1'b0;
            if (ld) begin
                m_count[k] = int'(data);
                m_state[k] = 1;
                m_tc[k]    = 1'b0;
            end else if (en && m_state[k] == 1) begin
                term = up ? 255 : 0;
                if (m_count[k] == term) begin
                    set = 1'b1;
                    hit = 1'b0;
                    nxt = cfg_sat[k] ? m_count[k] : (up ? 0 : 255);
                end else begin
                    nxt = up ? m_count[k] + 1 : m_count[k] - 1;
                    hit = (nxt == term);
                end
                m_count[k] = nxt;
                m_tc[k]    = hit;
                if (cfg_one[k] && hit) m_state[k] = 2;
            end else begin
                m_tc[k] = 1'b0;
            end
            if (set) m_ovf[k] = 1'b1;
            else if (clr_ovf) m_ovf[k] = 1'b0;
        end
    endfunction

    function automatic logic [11:0] obs(int k);
        return {d_count[k], d_tc[k], d_ovf[k], d_state[k]};
    endfunction

    function automatic logic [11:0] expv(int k);
        return {8'(m_count[k]), m_tc[k], m_ovf[k], 2'(m_state[k])};
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            model_reset();
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs(k) !== 12'h000) begin
                    failures++;
                    $display("FAIL reset_hold inst=%0d got=%h exp=000", k, obs(k));
                end
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs(k) !== expv(k) || obs(k) !== 12'h000) begin
                    failures++;
                    $display("FAIL idle_ignores_en inst=%0d got=%h exp=000", k, obs(k));
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_cnt [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        bit         exp_tc  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit         exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        ld = 1'b1; data = 8'hFD; en = 1'b0; clr_ovf = 1'b1;
        step();
        ld = 1'b0; en = 1'b1; up = 1'b1; clr_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({d_count[0], d_tc[0], d_ovf[0]} !== {exp_cnt[i], exp_tc[i], exp_ovf[i]}) begin
                failures++;
                $display("FAIL wrap_up step=%0d got=%h/%b/%b exp=%h/%b/%b", i, d_count[0], d_tc[0], d_ovf[0],
                         exp_cnt[i], exp_tc[i], exp_ovf[i]);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    failures++;
                    $display("FAIL wrap_model inst=%0d got=%h exp=%h", k, obs(k), expv(k));
                end
            end
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_cnt [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
        bit         exp_tc  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit         exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        ld = 1'b1; data = 8'h02; en = 1'b0; clr_ovf = 1'b1;
        step();
        ld = 1'b0; en = 1'b1; up = 1'b0; clr_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({d_count[1], d_tc[1], d_ovf[1]} !== {exp_cnt[i], exp_tc[i], exp_ovf[i]}) begin
                failures++;
                $display("FAIL sat_down step=%0d got=%h/%b/%b exp=%h/%b/%b", i, d_count[1], d_tc[1], d_ovf[1],
                         exp_cnt[i], exp_tc[i], exp_ovf[i]);
            end
        end
        en = 1'b0; clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++;
        if (d_ovf[1] !== 1'b0) begin
            failures++;
            $display("FAIL sat_clr_ovf got=%b exp=0", d_ovf[1]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                failures++;
                $display("FAIL sat_model inst=%0d got=%h exp=%h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_one_shot();
        logic [7:0] exp_cnt [6] = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [1:0] exp_st  [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
        ld = 1'b1; data = 8'h03; en = 1'b0; clr_ovf = 1'b1;
        step();
        ld = 1'b0; en = 1'b1; up = 1'b0; clr_ovf = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({d_count[2], d_state[2], d_ovf[2]} !== {exp_cnt[i], exp_st[i], 1'b0}) begin
                failures++;
                $display("FAIL one_shot step=%0d got=%h/%0d/%b exp=%h/%0d/0", i, d_count[2], d_state[2], d_ovf[2],
                         exp_cnt[i], exp_st[i]);
            end
        end
        ld = 1'b1; data = 8'h10;
        step();
        ld = 1'b0; en = 1'b0;
        checks++;
        if ({d_count[2], d_state[2]} !== {8'h10, 2'd1}) begin
            failures++;
            $display("FAIL one_shot_reload got=%h/%0d exp=10/1", d_count[2], d_state[2]);
        end
    endtask

    task automatic test_ld_priority();
        ld = 1'b1; data = 8'h55; en = 1'b1; up = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d_count[k] !== 8'h55 || obs(k) !== expv(k)) begin
                failures++;
                $display("FAIL ld_over_en inst=%0d got=%h exp=55", k, d_count[k]);
            end
        end
        data = 8'hFF; clr_ovf = 1'b1; en = 1'b0;
        step();
        ld = 1'b0; en = 1'b1; up = 1'b1; clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0; en = 1'b0;
        checks++;
        if ({d_count[0], d_ovf[0], d_tc[0]} !== {8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL ovf_set_beats_clr got=%h/%b/%b exp=00/1/0", d_count[0], d_ovf[0], d_tc[0]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                failures++;
                $display("FAIL prio_model inst=%0d got=%h exp=%h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_async_reset();
        ld = 1'b1; data = 8'h40; en = 1'b0;
        step();
        ld = 1'b0; en = 1'b1; up = 1'b1;
        data = 8'h3F;
        checks++;
        if ({d_count[0], d_state[0]} !== {8'h40, 2'd1}) begin
            failures++;
            $display("FAIL async_pre got=%h/%0d exp=40/1", d_count[0], d_state[0]);
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== 12'h000) begin
                failures++;
                $display("FAIL async_reset inst=%0d got=%h exp=000", k, obs(k));
            end
        end
        en = 1'b0;
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [7:0] picks [6] = '{8'h00, 8'h01, 8'h02, 8'hFD, 8'hFE, 8'hFF};
        for (int i = 0; i < 400; i++) begin
            ld      = ($urandom_range(0, 9) == 0);
            data    = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 5)] : 8'($urandom());
            en      = ($urandom_range(0, 3) != 0);
            up      = ($urandom_range(0, 4) != 0) ? up : ~up;
            clr_ovf = ($urandom_range(0, 9) == 0);
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    failures++;
                    $display("FAIL random cyc=%0d inst=%0d got=%h exp=%h", i, k, obs(k), expv(k));
                end
            end
        end
        ld = 1'b0; en = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_wrap();
        test_saturate();
        test_one_shot();
        test_ld_priority();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
